// File: rtl/common_pkg.sv
// common: shared scalar types and the architectural reset PC.
package common;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    localparam u64 PCINIT = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/pipes_pkg.sv
// pipes: pipeline-stage state encodings.
package pipes;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl_pcreg.sv
// pcreg: fetch PC register, loads PCINIT on reset and pc_nxt otherwise.
module pcreg
    import common::*;
(
    input  logic clk,
    input  logic reset,
    input  u64   pc_nxt,
    output u64   pc
);
    always_ff @(posedge clk) pc <= reset ? PCINIT : pc_nxt;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with stall hold and redirect draining.
// Define FETCH_CTRL_TRAP_EN to add the trap redirect port, which outranks redirect_valid.
module fetch_ctrl
    import common::*;
    import pipes::*;
(
    input  logic clk,
    input  logic reset,
    output logic ireq_valid,
    output u64   ireq_addr,
    input  logic iresp_data_ok,
    input  u32   iresp_data,
    input  logic stall,
    input  logic redirect_valid,
    input  u64   redirect_pc,
`ifdef FETCH_CTRL_TRAP_EN
    input  logic trap_valid,
    input  u64   trap_pc,
`endif
    output logic if_valid,
    output u64   if_pc,
    output u32   if_instr,
    output u64   pc
);
    fetch_state_t state_q, state_d;
    logic         if_valid_q, if_valid_d, redir;
    u64           if_pc_q, if_pc_d, stale_q, stale_d, pc_nxt, tgt;
    u32           if_instr_q, if_instr_d;

`ifdef FETCH_CTRL_TRAP_EN
    assign redir = trap_valid | redirect_valid;
    assign tgt   = trap_valid ? trap_pc : redirect_pc;
`else
    assign redir = redirect_valid;
    assign tgt   = redirect_pc;
`endif

    pcreg u_pcreg (.clk(clk), .reset(reset), .pc_nxt(pc_nxt), .pc(pc));

    // A redirect loads pc in every state; only FETCH can otherwise advance it.
    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        stale_d    = stale_q;
        pc_nxt     = redir ? tgt : pc;
        unique case (state_q)
            IDLE: begin
                state_d    = FETCH;
                if_valid_d = 1'b0;
            end
            FETCH: begin
                stale_d    = pc;
                if_valid_d = 1'b0;
                if (redir)
                    state_d = iresp_data_ok ? FETCH : DRAIN;
                else if (iresp_data_ok) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc;
                    if_instr_d = iresp_data;
                    pc_nxt     = pc + 64'd4;
                    state_d    = stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (redir || !stall) begin
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (iresp_data_ok) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            stale_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            stale_q    <= stale_d;
        end
    end

    // The superseded request stays on the bus with its original address while draining.
    assign ireq_valid = (state_q == FETCH) || (state_q == DRAIN);
    assign ireq_addr  = (state_q == DRAIN) ? stale_q : pc;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;
endmodule
